// File: rtl/timer_pkg.sv
// Shared types and constants for the microwave countdown timer controller.
`timescale 1ns/1ps
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSED = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;

  // Entry buffer is {min_tens, min_units, sec_tens, sec_units}; seconds tens above 5 is not a valid time.
  function automatic logic [15:0] clamp_load(input logic [15:0] entry);
    logic [15:0] r;
    r = entry;
    if (entry[7:4] > SEC_TENS_MAX) r[7:4] = SEC_TENS_MAX;
    return r;
  endfunction

endpackage

// File: rtl/timer_ctrl_tick_gen.sv
// Tick prescaler: counts while run is high, holds otherwise, clr restarts the period.
`timescale 1ns/1ps
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic clrn,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = run && (count == LAST);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (run) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Microwave timer sequencer: keypad entry, load, 1 Hz countdown enable, door interlock, completion.
// Optional buzzer sequencing is built when TIMER_CTRL_BEEP_EN is defined; otherwise beep is tied low.
//
// state  | meaning
// IDLE   | collecting keypad digits into the mm:ss entry buffer
// LOAD   | one-cycle parallel load of the counter chain
// RUN    | magnetron on, counter decremented once per tick
// PAUSED | door opened or stop pressed; counter and prescaler frozen
// DONE   | counter reached 00:00; done flag (and buzzer) active
`timescale 1ns/1ps
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int BEEP_TICKS = 3
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        door_closed,
  input  logic        time_zero,
  output logic [15:0] cnt_data,
  output logic        cnt_loadn,
  output logic        cnt_en,
  output logic        mag_on,
  output logic        done,
  output logic        beep
);

  if (TICK_DIV < 2 || BEEP_TICKS < 1) begin : g_param_check
    $error("timer_ctrl: TICK_DIV must be >= 2 and BEEP_TICKS >= 1");
  end

  state_t      state;
  logic [15:0] entry_buf;
  logic        key_ok;
  logic        tick;
  logic        presc_run;
  logic        presc_clr;

  assign key_ok = key_valid && (key_digit <= 4'd9);

  // The prescaler only advances in RUN cycles that stay in RUN, so a pause never swallows a tick.
  always_comb begin
    presc_run = 1'b0;
    presc_clr = 1'b0;
    case (state)
      ST_LOAD: presc_clr = 1'b1;
      ST_RUN: begin
        if (!clear && door_closed && !stop) begin
          if (time_zero) presc_clr = 1'b1;
          else           presc_run = 1'b1;
        end
      end
`ifdef TIMER_CTRL_BEEP_EN
      ST_DONE: presc_run = 1'b1;
`endif
      default: ;
    endcase
  end

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .clrn (clrn),
    .clr  (presc_clr),
    .run  (presc_run),
    .tick (tick)
  );

`ifdef TIMER_CTRL_BEEP_EN
  localparam int BW = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);
  logic [BW-1:0] beep_cnt;
`else
  assign beep = 1'b0;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= ST_IDLE;
      entry_buf <= '0;
      cnt_data  <= '0;
      cnt_loadn <= 1'b1;
      cnt_en    <= 1'b0;
      mag_on    <= 1'b0;
      done      <= 1'b0;
`ifdef TIMER_CTRL_BEEP_EN
      beep      <= 1'b0;
      beep_cnt  <= '0;
`endif
    end else begin
      cnt_loadn <= 1'b1;
      cnt_en    <= 1'b0;
      if (clear && state != ST_IDLE) begin
        // Loading 00:00 blanks the display on the way back to IDLE.
        state     <= ST_IDLE;
        entry_buf <= '0;
        cnt_data  <= '0;
        cnt_loadn <= 1'b0;
        cnt_en    <= 1'b1;
        mag_on    <= 1'b0;
        done      <= 1'b0;
`ifdef TIMER_CTRL_BEEP_EN
        beep      <= 1'b0;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            if (clear) begin
              entry_buf <= '0;
            end else if (stop) begin
            end else if (start) begin
              if (door_closed && entry_buf != '0) begin
                state     <= ST_LOAD;
                cnt_data  <= clamp_load(entry_buf);
                cnt_loadn <= 1'b0;
                cnt_en    <= 1'b1;
              end
            end else if (key_ok) begin
              entry_buf <= {entry_buf[11:0], key_digit};
            end
          end
          ST_LOAD: begin
            if (!door_closed || stop) begin
              state <= ST_PAUSED;
            end else begin
              state  <= ST_RUN;
              mag_on <= 1'b1;
            end
          end
          ST_RUN: begin
            if (!door_closed || stop) begin
              state  <= ST_PAUSED;
              mag_on <= 1'b0;
            end else if (time_zero) begin
              state  <= ST_DONE;
              mag_on <= 1'b0;
              done   <= 1'b1;
`ifdef TIMER_CTRL_BEEP_EN
              beep     <= 1'b1;
              beep_cnt <= '0;
`endif
            end else if (tick) begin
              cnt_en <= 1'b1;
            end
          end
          ST_PAUSED: begin
            if (door_closed && !stop && start) begin
              state  <= ST_RUN;
              mag_on <= 1'b1;
            end
          end
          ST_DONE: begin
            if (start || key_valid) begin
              state     <= ST_IDLE;
              entry_buf <= '0;
              done      <= 1'b0;
`ifdef TIMER_CTRL_BEEP_EN
              beep      <= 1'b0;
`endif
            end
`ifdef TIMER_CTRL_BEEP_EN
            else if (beep && tick) begin
              if (beep_cnt == BEEP_LAST) beep <= 1'b0;
              beep_cnt <= beep_cnt + BW'(1);
            end
`endif
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Randomised scenario bench for timer_ctrl with a decimal-arithmetic reference for buffer and tick timing.
`timescale 1ns/1ps
module tb_timer_ctrl;

  localparam int TD = 4;
  localparam int BT = 3;
`ifdef TIMER_CTRL_BEEP_EN
  localparam bit BEEP_EN = 1'b1;
`else
  localparam bit BEEP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        door_closed = 1'b1;
  logic        time_zero = 1'b0;
  logic [15:0] cnt_data;
  logic        cnt_loadn;
  logic        cnt_en;
  logic        mag_on;
  logic        done;
  logic        beep;

  int errors = 0;
  int checks = 0;
  int buf_model = 0;   // entry buffer as a decimal number 0..9999
  int n_run = 0;       // accumulated running cycles since the last load
  bit en_exp = 1'b0;

  always #5 clk = ~clk;

  timer_ctrl #(.TICK_DIV(TD), .BEEP_TICKS(BT)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .door_closed (door_closed),
    .time_zero   (time_zero),
    .cnt_data    (cnt_data),
    .cnt_loadn   (cnt_loadn),
    .cnt_en      (cnt_en),
    .mag_on      (mag_on),
    .done        (done),
    .beep        (beep)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int d);
    key_digit = 4'(d);
    key_valid = 1'b1;
    cyc();
    key_valid = 1'b0;
    if (d <= 9) buf_model = (buf_model * 10 + d) % 10000;
  endtask

  function automatic logic [15:0] exp_load(input int b);
    int mm, st, su;
    mm = b / 100;
    st = (b % 100) / 10;
    su = b % 10;
    if (st > 5) st = 5;
    return {4'(mm / 10), 4'(mm % 10), 4'(st), 4'(su)};
  endfunction

  // A decrement enable appears one cycle after every TD-th accumulated running cycle.
  task automatic run_for(input int n);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (cnt_en !== en_exp || mag_on !== 1'b1 || cnt_loadn !== 1'b1) begin
        errors++;
        $display("FAIL run_tick: cnt_en=%b mag_on=%b cnt_loadn=%b, required cnt_en=%b mag_on=1 cnt_loadn=1 (run cycles %0d)",
                 cnt_en, mag_on, cnt_loadn, en_exp, n_run);
      end
      n_run++;
      en_exp = (n_run % TD == 0);
      cyc();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cnt_data, cnt_loadn, cnt_en, mag_on, done, beep} !== {16'h0000, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL reset_state: got data=%h loadn=%b en=%b mag=%b done=%b beep=%b, required 0000 1 0 0 0 0",
               cnt_data, cnt_loadn, cnt_en, mag_on, done, beep);
    end
    clrn = 1'b1;
    cyc();
    checks++;
    if ({cnt_loadn, cnt_en, mag_on, done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_release_idle: got loadn=%b en=%b mag=%b done=%b, required 1 0 0 0",
               cnt_loadn, cnt_en, mag_on, done);
    end
    buf_model = 0;
  endtask

  task automatic test_empty_start();
    start = 1'b1; cyc(); start = 1'b0;
    checks++;
    if (cnt_loadn !== 1'b1 || cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL empty_start_load: got loadn=%b en=%b, required 1 0", cnt_loadn, cnt_en);
    end
    press(7);
    door_closed = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    checks++;
    if (cnt_loadn !== 1'b1) begin
      errors++;
      $display("FAIL door_open_start: got loadn=%b, required 1", cnt_loadn);
    end
    door_closed = 1'b1;
    clear = 1'b1; cyc(); clear = 1'b0;
    buf_model = 0;
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    checks++;
    if (cnt_loadn !== 1'b1 || mag_on !== 1'b0) begin
      errors++;
      $display("FAIL idle_clear_buffer: got loadn=%b mag=%b, required 1 0", cnt_loadn, mag_on);
    end
  endtask

  task automatic test_load_run();
    int nk;
    nk = $urandom_range(3, 6);
    for (int i = 0; i < nk; i++) begin
      if ($urandom_range(0, 4) == 0) press($urandom_range(10, 15));
      else                           press($urandom_range(0, 9));
    end
    press($urandom_range(1, 9));
    start = 1'b1; cyc(); start = 1'b0;
    checks++;
    if (cnt_loadn !== 1'b0 || cnt_en !== 1'b1 || cnt_data !== exp_load(buf_model) || mag_on !== 1'b0) begin
      errors++;
      $display("FAIL load_cycle: got data=%h loadn=%b en=%b mag=%b, required data=%h loadn=0 en=1 mag=0",
               cnt_data, cnt_loadn, cnt_en, mag_on, exp_load(buf_model));
    end
    cyc();
    n_run = 0;
    en_exp = 1'b0;
    run_for(13);
  endtask

  task automatic test_pause();
    run_for($urandom_range(0, 6));
    door_closed = 1'b0;
    en_exp = 1'b0;
    cyc();
    checks++;
    if (mag_on !== 1'b0 || cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL door_pause: got mag=%b en=%b, required 0 0", mag_on, cnt_en);
    end
    repeat ($urandom_range(1, 3)) cyc();
    door_closed = 1'b1;
    repeat ($urandom_range(1, 5)) begin
      cyc();
      checks++;
      if (mag_on !== 1'b0 || cnt_en !== 1'b0 || cnt_loadn !== 1'b1) begin
        errors++;
        $display("FAIL paused_hold: got mag=%b en=%b loadn=%b, required 0 0 1", mag_on, cnt_en, cnt_loadn);
      end
    end
    start = 1'b1; cyc(); start = 1'b0;
    run_for(9);
    stop = 1'b1; en_exp = 1'b0; cyc(); stop = 1'b0;
    checks++;
    if (mag_on !== 1'b0 || cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL stop_pause: got mag=%b en=%b, required 0 0", mag_on, cnt_en);
    end
    start = 1'b1; cyc(); start = 1'b0;
    run_for(6);
  endtask

  task automatic test_clear_start();
    clear = 1'b1; start = 1'b1; cyc(); clear = 1'b0; start = 1'b0;
    buf_model = 0;
    checks++;
    if (cnt_data !== 16'h0000 || cnt_loadn !== 1'b0 || cnt_en !== 1'b1 || mag_on !== 1'b0) begin
      errors++;
      $display("FAIL clear_zero_load: got data=%h loadn=%b en=%b mag=%b, required 0000 0 1 0",
               cnt_data, cnt_loadn, cnt_en, mag_on);
    end
    cyc();
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    checks++;
    if (cnt_loadn !== 1'b1 || mag_on !== 1'b0) begin
      errors++;
      $display("FAIL clear_buffer_empty: got loadn=%b mag=%b, required 1 0", cnt_loadn, mag_on);
    end
  endtask

  task automatic test_clamp();
    logic [15:0] req;
    for (int it = 0; it < 3; it++) begin
      if (it == 0) begin
        press(0); press(0); press(9); press(10); press(9);
        req = 16'h0059;
      end else begin
        press($urandom_range(0, 9)); press($urandom_range(0, 9));
        press($urandom_range(6, 9)); press($urandom_range(1, 9));
        req = exp_load(buf_model);
      end
      start = 1'b1; cyc(); start = 1'b0;
      checks++;
      if (cnt_data !== req || cnt_loadn !== 1'b0) begin
        errors++;
        $display("FAIL clamp_load: got data=%h loadn=%b, required data=%h loadn=0", cnt_data, cnt_loadn, req);
      end
      cyc();
      clear = 1'b1; cyc(); clear = 1'b0;
      buf_model = 0;
      cyc();
    end
  endtask

  task automatic test_done();
    press(1);
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    n_run = 0;
    en_exp = 1'b0;
    // Stop so that a tick would fall in the same cycle time_zero is seen.
    run_for(4 * $urandom_range(0, 1) + 3);
    time_zero = 1'b1;
    cyc();
    checks++;
    if (done !== 1'b1 || mag_on !== 1'b0 || cnt_en !== 1'b0) begin
      errors++;
      $display("FAIL done_entry: got done=%b mag=%b en=%b, required 1 0 0", done, mag_on, cnt_en);
    end
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (beep !== (BEEP_EN && j < BT * TD) || done !== 1'b1 || cnt_en !== 1'b0) begin
        errors++;
        $display("FAIL done_beep: cycle %0d got beep=%b done=%b en=%b, required beep=%b done=1 en=0",
                 j, beep, done, cnt_en, (BEEP_EN && j < BT * TD));
      end
      cyc();
    end
    key_digit = 4'd5; key_valid = 1'b1; cyc(); key_valid = 1'b0;
    time_zero = 1'b0;
    buf_model = 0;
    checks++;
    if (done !== 1'b0 || beep !== 1'b0) begin
      errors++;
      $display("FAIL done_exit_key: got done=%b beep=%b, required 0 0", done, beep);
    end
    start = 1'b1; cyc(); start = 1'b0;
    checks++;
    if (cnt_loadn !== 1'b1) begin
      errors++;
      $display("FAIL done_key_not_captured: got loadn=%b, required 1", cnt_loadn);
    end
  endtask

  task automatic test_reset_mid();
    press(4);
    start = 1'b1; cyc(); start = 1'b0;
    repeat (3) cyc();
    #2 clrn = 1'b0;
    #1;
    checks++;
    if ({cnt_data, cnt_loadn, cnt_en, mag_on, done, beep} !== {16'h0000, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL async_reset: got data=%h loadn=%b en=%b mag=%b done=%b beep=%b, required 0000 1 0 0 0 0",
               cnt_data, cnt_loadn, cnt_en, mag_on, done, beep);
    end
    #3 clrn = 1'b1;
    buf_model = 0;
    cyc();
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    checks++;
    if (mag_on !== 1'b0 || cnt_loadn !== 1'b1) begin
      errors++;
      $display("FAIL reset_buffer_empty: got mag=%b loadn=%b, required 0 1", mag_on, cnt_loadn);
    end
  endtask

  initial begin
    test_reset();
    test_empty_start();
    test_load_run();
    test_pause();
    test_clear_start();
    test_clamp();
    test_done();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Sequencing controller for the microwave countdown timer. Collects keypad digits into an mm:ss buffer and loads it into the four-digit mod-10 down-counter chain. Generates the 1 Hz decrement enable, handles start/stop/clear and the door interlock, drives the magnetron enable, and flags completion. Sits between the keypad/door inputs and the timer datapath.

## Interface
- TICK_DIV, 50_000_000: clk cycles per countdown tick (1 s at 50 MHz); minimum 2.
- BEEP_TICKS, 3: number of ticks `beep` stays high in DONE (only with beep feature).
- clk  in  1  system clock, rising edge.
- clrn  in  1  reset; one clock, asynchronous, active-low.
- key_valid  in  1  one-cycle strobe, `key_digit` valid.
- key_digit  in  4  BCD digit from keypad.
- start  in  1  one-cycle strobe.
- stop  in  1  one-cycle strobe.
- clear  in  1  one-cycle strobe.
- door_closed  in  1  level, 1 = door shut.
- time_zero  in  1  AND of the four counter `zero` flags (counter reads 00:00).
- cnt_data  out  16  load value {min_tens, min_units, sec_tens, sec_units}.
- cnt_loadn  out  1  active-low load to counter chain.
- cnt_en  out  1  counter enable (load qualifier or decrement tick).
- mag_on  out  1  magnetron enable.
- done  out  1  high in DONE state.
- beep  out  1  buzzer drive.

## Operation
- States: IDLE, LOAD, RUN, PAUSED, DONE. Reset: IDLE, entry buffer 0000, cnt_data 0, cnt_loadn 1, cnt_en/mag_on/done/beep 0, prescaler 0.
- Input priority when strobes coincide: clear > door open > stop > start > key_valid.
- IDLE:
  - key_valid with digit ≤ 9: buffer shifts left one digit, new digit enters sec_units, top digit drops.
  - Digits > 9 are ignored.
  - clear: buffer ← 0000.
  - start with door_closed and buffer ≠ 0000: go to LOAD.
  - start with buffer = 0000 or door open: ignored.
- LOAD (one cycle):
  - cnt_data = buffer, with sec_tens clamped to 5 if > 5; cnt_loadn 0, cnt_en 1.
  - Prescaler cleared; go to RUN.
- RUN:
  - mag_on 1; prescaler counts.
  - cnt_en pulses 1 cycle when prescaler reaches TICK_DIV-1; prescaler then wraps to 0.
  - time_zero 1: cnt_en forced 0 so the chain never wraps to 99:99; go to DONE.
  - Door opens or stop: go to PAUSED.
  - start: ignored.
- PAUSED:
  - mag_on 0; prescaler holds its value and the counter holds.
  - start with door_closed: return to RUN without reload; the partial second resumes.
- DONE: mag_on 0, done 1.
- Clear path:
  - clear in RUN, PAUSED or DONE: go to IDLE, buffer ← 0000.
  - In that transition cycle: cnt_data 0000, cnt_loadn 0, cnt_en 1 (zeroes the display).
- Leaving DONE: start or key_valid also returns to IDLE with buffer 0000. The key_valid digit is not captured.
- Reset mid-operation: immediate return to reset values; mag_on drops asynchronously.

## Timing
- All outputs registered; state change visible the cycle after the causing strobe.
- start → LOAD is 1 cycle; LOAD → RUN is 1 cycle. mag_on rises 2 cycles after start.
- First decrement tick: TICK_DIV cycles after entering RUN. Subsequent ticks: every TICK_DIV cycles.
- time_zero sampled every cycle in RUN. The DONE entry cycle and mag_on fall happen 1 cycle after time_zero is seen high.
- Door open: mag_on low 1 cycle after door_closed falls.

## Configuration
- TIMER_CTRL_BEEP_EN defined: tick prescaler keeps running in DONE; beep high from DONE entry for BEEP_TICKS ticks, then low; cleared on DONE exit.
- Undefined: beep tied 0, BEEP_TICKS unused; all other behaviour identical.

## Structure
- Package timer_pkg: state enum encoding, BCD digit type, SEC_TENS_MAX = 5 constant.
- Sub-module tick_gen: prescaler with clear/hold controls and one-cycle tick output, parameterised by TICK_DIV.

## Test plan
- TICK_DIV=4:
  - Keys 1,2,3 then start → cnt_data 0x0123 with cnt_loadn 0 for one cycle.
  - mag_on 1; cnt_en pulses every 4 cycles.
- Keys 0,0,9,9 + start → cnt_data 0x0059 (sec_tens clamped).
- key_digit 0xA ignored; buffer unchanged.
- RUN, drop door_closed → PAUSED, mag_on 0 next cycle.
  - Re-close door alone → stays PAUSED.
  - start → RUN, next tick after the remaining prescaler count, no load.
- Model time_zero rising in RUN → no further cnt_en, DONE next cycle.
  - done 1; with TIMER_CTRL_BEEP_EN, beep 1 for 12 cycles (3 ticks).
- clear and start in the same cycle during RUN → IDLE.
  - Zero-load cycle issued (cnt_data 0, cnt_loadn 0); buffer 0000; mag_on 0.
- Assert clrn low during RUN → all outputs at reset values without a clock edge; start with empty buffer ignored.
